rf_write_ctrl: RTL and testbench

//  Sequencer and arbiter for the single write port of the 32-entry register file.

---
 rtl/rf_write_ctrl_pkg.sv | 13 +
 rtl/rf_write_ctrl_if.sv | 34 +++
 rtl/rf_write_ctrl_arb.sv | 29 ++
 rtl/rf_write_ctrl.sv | 129 ++++++++++++
 tb/tb_rf_write_ctrl.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/rf_write_ctrl_pkg.sv
// rtl/rf_write_ctrl_pkg.sv - shared types and constants for the register-file write controller
package rf_ctrl_pkg;

  typedef enum logic {ST_CLEAR, ST_RUN} rf_ctrl_state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_NUM_REGS   = 32;

endpackage

// File: rtl/rf_write_ctrl_if.sv
// rtl/rf_write_ctrl_if.sv - writeback source handshakes and register-file write port bundle
interface rf_write_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);

  logic                  i_a_valid;
  logic                  o_a_ready;
  logic [ADDR_WIDTH-1:0] i_a_addr;
  logic [DATA_WIDTH-1:0] i_a_data;
  logic                  i_b_valid;
  logic                  o_b_ready;
  logic [ADDR_WIDTH-1:0] i_b_addr;
  logic [DATA_WIDTH-1:0] i_b_data;
  logic                  o_rf_we;
  logic [ADDR_WIDTH-1:0] o_rf_waddr;
  logic [DATA_WIDTH-1:0] o_rf_wdata;
  logic                  o_init_done;

  modport master (
    output i_a_valid, i_a_addr, i_a_data,
    output i_b_valid, i_b_addr, i_b_data,
    input  o_a_ready, o_b_ready,
    input  o_rf_we, o_rf_waddr, o_rf_wdata, o_init_done
  );

  modport slave (
    input  i_a_valid, i_a_addr, i_a_data,
    input  i_b_valid, i_b_addr, i_b_data,
    output o_a_ready, o_b_ready,
    output o_rf_we, o_rf_waddr, o_rf_wdata, o_init_done
  );

endinterface

// File: rtl/rf_write_ctrl_arb.sv
// rtl/rf_write_ctrl_arb.sv - two-way round-robin arbiter (rr_arb2)
// The pointer only moves when both sources compete and advance is set.
module rr_arb2
  import rf_ctrl_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       ptr_nxt
);

  always_comb begin
    gnt     = 2'b00;
    ptr_nxt = ptr;
    case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        gnt = (ptr == REQ_B) ? 2'b10 : 2'b01;
        if (advance) begin
          ptr_nxt = ~ptr;
        end
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/rf_write_ctrl.sv
// rtl/rf_write_ctrl.sv - register-file write port sequencer: post-reset clear sweep, then A/B round-robin
// RF_CLEAR_EN enables the zeroing sweep of addresses 1..NUM_REGS-1 after reset.
module rf_write_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  rf_write_ctrl_if.slave bus
);

`ifdef RF_CLEAR_EN
  localparam rf_ctrl_state_t        RESET_STATE = ST_CLEAR;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(NUM_REGS - 1);
`else
  localparam rf_ctrl_state_t        RESET_STATE = ST_RUN;
`endif

  rf_ctrl_state_t        state_q;
  rf_ctrl_state_t        state_d;
  logic                  ptr_q;
  logic                  ptr_nxt;
  logic                  run;
  logic [1:0]            req;
  logic [1:0]            gnt;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  wr_ok;

`ifdef RF_CLEAR_EN
  logic [ADDR_WIDTH-1:0] cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= ADDR_WIDTH'(1);
    end else if (state_q == ST_CLEAR) begin
      cnt_q <= cnt_q + ADDR_WIDTH'(1);
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef RF_CLEAR_EN
      ST_CLEAR: if (cnt_q == LAST_ADDR) state_d = ST_RUN;
`else
      ST_CLEAR: state_d = ST_RUN;
`endif
      ST_RUN:   state_d = ST_RUN;
    endcase
  end

  // Readies are gated by reset so nothing is handshaken while the block is held in reset.
  always_comb begin
    run           = (state_q == ST_RUN) && i_rst_n;
    req           = {bus.i_b_valid, bus.i_a_valid} & {2{run}};
    bus.o_a_ready = gnt[0];
    bus.o_b_ready = gnt[1];
    accept        = |gnt;
    sel_addr      = gnt[1] ? bus.i_b_addr : bus.i_a_addr;
    sel_data      = gnt[1] ? bus.i_b_data : bus.i_a_data;
    wr_ok         = (sel_addr != '0) && (32'(sel_addr) < NUM_REGS);
  end

  rr_arb2 u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .advance (run),
    .gnt     (gnt),
    .ptr_nxt (ptr_nxt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= REQ_A;
    end else begin
      ptr_q <= ptr_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_rf_we    <= 1'b0;
      bus.o_rf_waddr <= '0;
      bus.o_rf_wdata <= '0;
    end else if (state_q == ST_CLEAR) begin
`ifdef RF_CLEAR_EN
      bus.o_rf_we    <= 1'b1;
      bus.o_rf_waddr <= cnt_q;
      bus.o_rf_wdata <= '0;
`else
      bus.o_rf_we    <= 1'b0;
`endif
    end else if (accept) begin
      // r0 writes are consumed from the source but never reach the file.
      bus.o_rf_we    <= wr_ok;
      bus.o_rf_waddr <= sel_addr;
      bus.o_rf_wdata <= sel_data;
    end else begin
      bus.o_rf_we    <= 1'b0;
    end
  end

`ifdef RF_CLEAR_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_init_done <= 1'b0;
    end else if (state_q == ST_RUN) begin
      bus.o_init_done <= 1'b1;
    end
  end
`else
  assign bus.o_init_done = 1'b1;
`endif

endmodule

// File: tb/tb_rf_write_ctrl.sv
// tb/tb_rf_write_ctrl.sv - directed self-checking bench for rf_write_ctrl
module tb_rf_write_ctrl;

`ifdef RF_CLEAR_EN
  localparam logic INIT_RST = 1'b0;
`else
  localparam logic INIT_RST = 1'b1;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  rf_write_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  rf_write_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [4:0]  rr_addr [4];
  logic [31:0] rr_data [4];

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rr_addr  = '{5'd1, 5'd2, 5'd1, 5'd2};
    rr_data  = '{32'hA1, 32'hB2, 32'hA1, 32'hB2};

    rst_n         = 1'b0;
    bus.i_a_valid = 1'b1;
    bus.i_a_addr  = 5'd3;
    bus.i_a_data  = 32'h11;
    bus.i_b_valid = 1'b1;
    bus.i_b_addr  = 5'd4;
    bus.i_b_data  = 32'h22;
    #12;
    check("rst_a_ready", 32'(bus.o_a_ready), 32'd0);
    check("rst_b_ready", 32'(bus.o_b_ready), 32'd0);
    check("rst_we",      32'(bus.o_rf_we), 32'd0);
    check("rst_waddr",   32'(bus.o_rf_waddr), 32'd0);
    check("rst_wdata",   bus.o_rf_wdata, 32'd0);
    check("rst_init",    32'(bus.o_init_done), 32'(INIT_RST));

    @(posedge clk);
    #1;
    rst_n = 1'b1;

`ifdef RF_CLEAR_EN
    #1;
    check("sweep_a_ready", 32'(bus.o_a_ready), 32'd0);
    check("sweep_b_ready", 32'(bus.o_b_ready), 32'd0);
    for (int i = 1; i <= 9; i++) begin
      step();
      check("pre_sweep_we",    32'(bus.o_rf_we), 32'd1);
      check("pre_sweep_waddr", 32'(bus.o_rf_waddr), 32'(i));
      check("pre_sweep_ready", 32'({bus.o_b_ready, bus.o_a_ready}), 32'd0);
    end
    #1;
    rst_n = 1'b0;
    bus.i_a_valid = 1'b0;
    bus.i_b_valid = 1'b0;
    #1;
    check("mid_sweep_rst_we",    32'(bus.o_rf_we), 32'd0);
    check("mid_sweep_rst_waddr", 32'(bus.o_rf_waddr), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      step();
      check("sweep_we",    32'(bus.o_rf_we), 32'd1);
      check("sweep_waddr", 32'(bus.o_rf_waddr), 32'(i));
      check("sweep_wdata", bus.o_rf_wdata, 32'd0);
      check("sweep_init",  32'(bus.o_init_done), 32'd0);
    end
    step();
    check("sweep_end_we",   32'(bus.o_rf_we), 32'd0);
    check("sweep_end_init", 32'(bus.o_init_done), 32'd1);
`else
    bus.i_b_valid = 1'b0;
    #1;
    check("first_a_ready", 32'(bus.o_a_ready), 32'd1);
    check("first_init",    32'(bus.o_init_done), 32'd1);
    step();
    check("first_we",    32'(bus.o_rf_we), 32'd1);
    check("first_waddr", 32'(bus.o_rf_waddr), 32'd3);
    check("first_wdata", bus.o_rf_wdata, 32'h11);
    bus.i_a_valid = 1'b0;
    step();
    check("first_idle_we", 32'(bus.o_rf_we), 32'd0);
`endif

    bus.i_a_valid = 1'b1;
    bus.i_a_addr  = 5'd5;
    bus.i_a_data  = 32'hDEADBEEF;
    #1;
    check("a_only_a_ready", 32'(bus.o_a_ready), 32'd1);
    check("a_only_b_ready", 32'(bus.o_b_ready), 32'd0);
    step();
    check("a_only_we",    32'(bus.o_rf_we), 32'd1);
    check("a_only_waddr", 32'(bus.o_rf_waddr), 32'd5);
    check("a_only_wdata", bus.o_rf_wdata, 32'hDEADBEEF);
    bus.i_a_valid = 1'b0;
    step();
    check("idle_we",    32'(bus.o_rf_we), 32'd0);
    check("idle_waddr", 32'(bus.o_rf_waddr), 32'd5);
    check("idle_wdata", bus.o_rf_wdata, 32'hDEADBEEF);

    bus.i_a_valid = 1'b1;
    bus.i_a_addr  = 5'd1;
    bus.i_a_data  = 32'hA1;
    bus.i_b_valid = 1'b1;
    bus.i_b_addr  = 5'd2;
    bus.i_b_data  = 32'hB2;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_a_ready", 32'(bus.o_a_ready), 32'((k % 2) == 0));
      check("rr_b_ready", 32'(bus.o_b_ready), 32'((k % 2) == 1));
      step();
      check("rr_we",    32'(bus.o_rf_we), 32'd1);
      check("rr_waddr", 32'(bus.o_rf_waddr), 32'(rr_addr[k]));
      check("rr_wdata", bus.o_rf_wdata, rr_data[k]);
    end

    bus.i_a_valid = 1'b0;
    bus.i_b_addr  = 5'd0;
    bus.i_b_data  = 32'h1;
    #1;
    check("r0_b_ready", 32'(bus.o_b_ready), 32'd1);
    check("r0_a_ready", 32'(bus.o_a_ready), 32'd0);
    step();
    check("r0_we", 32'(bus.o_rf_we), 32'd0);

    bus.i_b_addr = 5'd9;
    bus.i_b_data = 32'h99;
    #1;
    check("b_only_b_ready", 32'(bus.o_b_ready), 32'd1);
    step();
    check("b_only_we",    32'(bus.o_rf_we), 32'd1);
    check("b_only_waddr", 32'(bus.o_rf_waddr), 32'd9);
    check("b_only_wdata", bus.o_rf_wdata, 32'h99);

    bus.i_a_valid = 1'b1;
    bus.i_a_addr  = 5'd6;
    bus.i_a_data  = 32'h66;
    #1;
    check("after_uncontested_a_ready", 32'(bus.o_a_ready), 32'd1);
    check("after_uncontested_b_ready", 32'(bus.o_b_ready), 32'd0);
    bus.i_b_valid = 1'b0;
    step();
    check("pend_we",    32'(bus.o_rf_we), 32'd1);
    check("pend_waddr", 32'(bus.o_rf_waddr), 32'd6);
    #1;
    rst_n = 1'b0;
    #1;
    check("op_rst_we",      32'(bus.o_rf_we), 32'd0);
    check("op_rst_waddr",   32'(bus.o_rf_waddr), 32'd0);
    check("op_rst_wdata",   bus.o_rf_wdata, 32'd0);
    check("op_rst_a_ready", 32'(bus.o_a_ready), 32'd0);
    check("op_rst_init",    32'(bus.o_init_done), 32'(INIT_RST));
    bus.i_a_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
`ifdef RF_CLEAR_EN
    check("restart_we",    32'(bus.o_rf_we), 32'd1);
    check("restart_waddr", 32'(bus.o_rf_waddr), 32'd1);
    check("restart_wdata", bus.o_rf_wdata, 32'd0);
`else
    check("restart_we",   32'(bus.o_rf_we), 32'd0);
    check("restart_init", 32'(bus.o_init_done), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
